// File: rtl/alu_2bit.sv
// alu_2bit: two-bit arithmetic/logic unit with zero and carry/borrow flags.
// The result and flags are available combinationally and also through a
// register stage with a capture enable and an asynchronous active-high reset.
// Build option: define ALU_DIV_EN to include the divider on OP 011. Without it,
// OP 011 returns out = 00, z = 1, c = 0 and no divider is built.
module alu_2bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [2:0] OP,
  input  logic       en,
  output logic [1:0] out,
  output logic       z,
  output logic       c,
  output logic [1:0] out_q,
  output logic       z_q,
  output logic       c_q
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  op_e        op;
  logic [1:0] res;
  logic       cy;

  assign op = op_e'(OP);

  // Result and carry/borrow/error flag for the selected operation
  always_comb begin
    res = '0;
    cy  = 1'b0;
    case (op)
      OP_ADD: {cy, res} = {1'b0, A} + {1'b0, B};
      OP_SUB: begin
        res = A - B;
        cy  = (A < B);
      end
      // 2-bit context keeps only the low product bits
      OP_MUL: res = A * B;
      OP_DIV: begin
`ifdef ALU_DIV_EN
        if (B == 2'b00) begin
          res = '1;
          cy  = 1'b1;
        end else begin
          res = A / B;
        end
`else
        res = '0;
`endif
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      default: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  assign out = res;
  assign z   = (res == 2'b00);
  assign c   = cy;

  // Registered copy of result and flags; reset clears, en gates capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else if (en) begin
      out_q <= out;
      z_q   <= z;
      c_q   <= c;
    end
  end

endmodule

// File: tb/tb_alu_2bit.sv
// tb_alu_2bit: directed test-plan vectors plus randomized stimulus checked
// against an arithmetic reference model of the ALU and its register stage.
module tb_alu_2bit;

  logic       clk;
  logic       rst;
  logic [1:0] A;
  logic [1:0] B;
  logic [2:0] OP;
  logic       en;
  logic [1:0] out;
  logic       z;
  logic       c;
  logic [1:0] out_q;
  logic       z_q;
  logic       c_q;

  int checks = 0;
  int errors = 0;

  alu_2bit dut (
    .clk   (clk),
    .rst   (rst),
    .A     (A),
    .B     (B),
    .OP    (OP),
    .en    (en),
    .out   (out),
    .z     (z),
    .c     (c),
    .out_q (out_q),
    .z_q   (z_q),
    .c_q   (c_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {c, z, out} computed with plain integer arithmetic
  function automatic logic [3:0] ref_alu(int a, int b, int op);
    int r;
    int cf;
    cf = 0;
    case (op)
      0: begin r = a + b; cf = (r > 3) ? 1 : 0; r = r % 4; end
      1: begin cf = (a < b) ? 1 : 0; r = (a - b + 4) % 4; end
      2: r = (a * b) % 4;
      3: begin
`ifdef ALU_DIV_EN
        if (b == 0) begin r = 3; cf = 1; end
        else r = a / b;
`else
        r = 0;
`endif
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = 3 - a;
    endcase
    return {cf[0], (r == 0), r[1:0]};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed={c,z,out}=%b expected=%b", tag, obs, exp);
    end
  endtask

  logic [3:0] sweep1 [8];
  logic [3:0] sweep2 [8];
  logic [3:0] exp_q;
  logic [3:0] held;

  initial begin
    // Test-plan tables, {c, z, out}
    sweep1 = '{4'b1010, 4'b0100, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0100, 4'b0100};
    sweep2 = '{4'b0011, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0011, 4'b0011, 4'b0001};
`ifndef ALU_DIV_EN
    sweep1[3] = 4'b0100;
    sweep2[3] = 4'b0100;
`endif

    rst = 1'b1; en = 1'b0; A = '0; B = '0; OP = '0;
    #1;
    check("reset_regs", {c_q, z_q, out_q}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Directed sweeps
    for (int i = 0; i < 8; i++) begin
      A = 2'b11; B = 2'b11; OP = i[2:0];
      #1;
      check($sformatf("sweep11_op%0d", i), {c, z, out}, sweep1[i]);
    end
    for (int i = 0; i < 8; i++) begin
      A = 2'b10; B = 2'b01; OP = i[2:0];
      #1;
      check($sformatf("sweep10_01_op%0d", i), {c, z, out}, sweep2[i]);
    end

    A = 2'b01; B = 2'b10; OP = 3'b001;
    #1;
    check("sub_borrow", {c, z, out}, 4'b1011);
    A = 2'b10; B = 2'b00; OP = 3'b011;
    #1;
`ifdef ALU_DIV_EN
    check("div_by_zero", {c, z, out}, 4'b1011);
`else
    check("div_disabled", {c, z, out}, 4'b0100);
`endif

    // Registered path: capture then hold
    @(negedge clk);
    en = 1'b1; A = 2'b11; B = 2'b11; OP = 3'b000;
    @(posedge clk); #1;
    check("reg_capture", {c_q, z_q, out_q}, 4'b1010);
    @(negedge clk);
    en = 1'b0; A = 2'b01; B = 2'b00; OP = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    check("reg_hold", {c_q, z_q, out_q}, 4'b1010);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    A = 2'b11; B = 2'b11; OP = 3'b000;
    #1;
    held = {c, z, out};
    rst = 1'b1;
    #1;
    check("async_rst_regs", {c_q, z_q, out_q}, 4'b0000);
    check("async_rst_comb", {c, z, out}, held);
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_beats_en", {c_q, z_q, out_q}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_capture", {c_q, z_q, out_q}, 4'b1010);
    exp_q = 4'b1010;

    // Randomized operation against the reference model
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      A  = 2'($urandom_range(0, 3));
      B  = 2'($urandom_range(0, 3));
      OP = 3'($urandom_range(0, 7));
      en = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("rand_comb_%0d", n), {c, z, out}, ref_alu(int'(A), int'(B), int'(OP)));
      if (en) exp_q = ref_alu(int'(A), int'(B), int'(OP));
      @(posedge clk); #1;
      check($sformatf("rand_reg_%0d", n), {c_q, z_q, out_q}, exp_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
